// File: rtl/i2c_rx_deser_pkg.sv
// i2c_pkg: shared types and defaults for the I2C receive deserialiser.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK
  } rx_state_t;

  localparam int I2C_ADDR_WIDTH_DEFAULT = 7;
  localparam int I2C_DATA_WIDTH_DEFAULT = 8;

  // Larger of two integers, used to size the shared shifter and counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/i2c_rx_deser_if.sv
// i2c_rx_deser_if: serial inputs, framing strobes and the receive handshake.
// The slave modport is the deserialiser side; master is the driving side.
interface i2c_rx_deser_if
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = I2C_DATA_WIDTH_DEFAULT
);
  logic                  sda_in;
  logic                  rising_edge_found;
  logic                  start_found;
  logic                  stop_found;
  logic                  rx_enable;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  addr_done;
  logic                  addr_match;
  logic                  rw_bit;
  logic                  ack_slot;
  logic                  overrun;

  modport slave (
    input  sda_in, rising_edge_found, start_found, stop_found, rx_enable, rx_ready,
    output rx_data, rx_valid, addr_done, addr_match, rw_bit, ack_slot, overrun
  );

  modport master (
    output sda_in, rising_edge_found, start_found, stop_found, rx_enable, rx_ready,
    input  rx_data, rx_valid, addr_done, addr_match, rw_bit, ack_slot, overrun
  );
endinterface

// File: rtl/i2c_rx_deser_sr.sv
// flex_stp_sr: serial-in / parallel-out shift register, direction selectable.
module flex_stp_sr #(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                i_shift_enable,
  input  logic                i_serial_in,
  output logic [NUM_BITS-1:0] o_parallel_out
);
  logic [NUM_BITS-1:0] r_sr;

  // Shift one bit in per enable; new bit enters at the LSB (MSB-first) or MSB.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sr <= '0;
    end else if (i_shift_enable) begin
      if (SHIFT_MSB) r_sr <= {r_sr[NUM_BITS-2:0], i_serial_in};
      else           r_sr <= {i_serial_in, r_sr[NUM_BITS-1:1]};
    end
  end

  assign o_parallel_out = r_sr;
endmodule

// File: rtl/i2c_rx_deser.sv
// i2c_rx_deser: I2C slave receive deserialiser. Tracks framing, decodes the
// address byte, skips ACK slots and presents data words through a
// valid/ready holding register with sticky overrun.
// Optional SDA glitch filter: define I2C_RX_SDA_FILTER_EN (adds 2 clk latency).
module i2c_rx_deser
  import i2c_pkg::*;
#(
  parameter int                  DATA_WIDTH = I2C_DATA_WIDTH_DEFAULT,
  parameter int                  ADDR_WIDTH = I2C_ADDR_WIDTH_DEFAULT,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR = ADDR_WIDTH'(7'h1E),
  parameter bit                  SHIFT_MSB  = 1'b1
) (
  input logic           clk,
  input logic           n_rst,
  i2c_rx_deser_if.slave bus
);
  localparam int N  = max_int(DATA_WIDTH, ADDR_WIDTH + 1);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_ADDR_LAST = CW'(ADDR_WIDTH);
  localparam logic [CW-1:0] CNT_DATA_LAST = CW'(DATA_WIDTH - 1);

  logic w_sda, w_rise, w_start, w_stop;

`ifdef I2C_RX_SDA_FILTER_EN
  logic [2:0] r_sda_q;
  logic [1:0] r_rise_d, r_start_d, r_stop_d;

  // SDA majority filter; strobes delayed 2 clk so they line up with the vote.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sda_q   <= 3'b111;
      r_rise_d  <= 2'b00;
      r_start_d <= 2'b00;
      r_stop_d  <= 2'b00;
    end else begin
      r_sda_q   <= {r_sda_q[1:0], bus.sda_in};
      r_rise_d  <= {r_rise_d[0], bus.rising_edge_found};
      r_start_d <= {r_start_d[0], bus.start_found};
      r_stop_d  <= {r_stop_d[0], bus.stop_found};
    end
  end

  assign w_sda   = (r_sda_q[0] & r_sda_q[1]) | (r_sda_q[1] & r_sda_q[2]) | (r_sda_q[0] & r_sda_q[2]);
  assign w_rise  = r_rise_d[1];
  assign w_start = r_start_d[1];
  assign w_stop  = r_stop_d[1];
`else
  assign w_sda   = bus.sda_in;
  assign w_rise  = bus.rising_edge_found;
  assign w_start = bus.start_found;
  assign w_stop  = bus.stop_found;
`endif

  rx_state_t             r_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid, r_addr_done, r_addr_match, r_rw_bit, r_ack_slot, r_overrun;

  logic                  w_sample, w_shift_en;
  logic [N-1:0]          w_sr, w_sr_next;
  logic [DATA_WIDTH-1:0] w_word;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_rw;
  logic                  w_unused_sr;

  // Framing strobes take priority, so a coincident sample is never shifted.
  assign w_sample   = bus.rx_enable & w_rise;
  assign w_shift_en = w_sample & ~w_start & ~w_stop & ((r_state == ADDR) | (r_state == DATA));

  flex_stp_sr #(
    .NUM_BITS (N),
    .SHIFT_MSB(SHIFT_MSB)
  ) u_sr (
    .clk           (clk),
    .n_rst         (n_rst),
    .i_shift_enable(w_shift_en),
    .i_serial_in   (w_sda),
    .o_parallel_out(w_sr)
  );

  // The completing bit is still on SDA, so decode from the post-shift view.
  generate
    if (SHIFT_MSB) begin : g_msb
      assign w_sr_next = {w_sr[N-2:0], w_sda};
      assign w_word    = w_sr_next[DATA_WIDTH-1:0];
      assign w_addr    = w_sr_next[ADDR_WIDTH:1];
      assign w_rw      = w_sr_next[0];
    end else begin : g_lsb
      assign w_sr_next = {w_sda, w_sr[N-1:1]};
      assign w_word    = w_sr_next[N-1 -: DATA_WIDTH];
      assign w_addr    = w_sr_next[N-2 -: ADDR_WIDTH];
      assign w_rw      = w_sr_next[N-1];
    end
  endgenerate

  // The bit pushed out of the shifter on each step is not needed here.
  assign w_unused_sr = ^w_sr;

  // Framing FSM, bit counter, address decode and data holding register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_addr_done  <= 1'b0;
      r_addr_match <= 1'b0;
      r_rw_bit     <= 1'b0;
      r_ack_slot   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_addr_done <= 1'b0;
      if (r_rx_valid && bus.rx_ready) r_rx_valid <= 1'b0;

      if (w_start) begin
        r_state      <= ADDR;
        r_cnt        <= '0;
        r_addr_match <= 1'b0;
        r_rw_bit     <= 1'b0;
        r_ack_slot   <= 1'b0;
        r_overrun    <= 1'b0;
      end else if (w_stop) begin
        r_state      <= IDLE;
        r_cnt        <= '0;
        r_addr_match <= 1'b0;
        r_rw_bit     <= 1'b0;
        r_ack_slot   <= 1'b0;
      end else if (w_sample) begin
        case (r_state)
          ADDR: begin
            if (r_cnt == CNT_ADDR_LAST) begin
              r_addr_match <= (w_addr == SLAVE_ADDR);
              r_rw_bit     <= w_rw;
              r_addr_done  <= 1'b1;
              r_ack_slot   <= 1'b1;
              r_cnt        <= '0;
              r_state      <= ADDR_ACK;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          ADDR_ACK: begin
            r_ack_slot <= 1'b0;
            r_state    <= r_addr_match ? DATA : IDLE;
          end
          DATA: begin
            if (r_cnt == CNT_DATA_LAST) begin
              r_rx_data  <= w_word;
              r_rx_valid <= 1'b1;
              if (r_rx_valid && !bus.rx_ready) r_overrun <= 1'b1;
              r_ack_slot <= 1'b1;
              r_cnt      <= '0;
              r_state    <= DATA_ACK;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          DATA_ACK: begin
            r_ack_slot <= 1'b0;
            r_cnt      <= '0;
            r_state    <= DATA;
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign bus.rx_data    = r_rx_data;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.addr_done  = r_addr_done;
  assign bus.addr_match = r_addr_match;
  assign bus.rw_bit     = r_rw_bit;
  assign bus.ack_slot   = r_ack_slot;
  assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_i2c_rx_deser.sv
// tb_i2c_rx_deser: scoreboard bench. The driver pushes expected address
// decodes and data words as it serialises them; monitors pop and compare
// whenever the DUT pulses addr_done or hands off a word.
module tb_i2c_rx_deser;
  localparam logic [6:0] SLAVE = 7'h1E;

  logic clk = 1'b0;
  logic n_rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_rx_deser_if #(.DATA_WIDTH(8)) bus ();
  i2c_rx_deser_if #(.DATA_WIDTH(4)) bus2 ();

  i2c_rx_deser #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .SLAVE_ADDR(7'h1E), .SHIFT_MSB(1'b1))
    u_dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  i2c_rx_deser #(.DATA_WIDTH(4), .ADDR_WIDTH(7), .SLAVE_ADDR(7'h1E), .SHIFT_MSB(1'b0))
    u_dut_lsb (.clk(clk), .n_rst(n_rst), .bus(bus2));

  typedef struct { logic [7:0] data; int t; bit lat; } word_t;
  typedef struct { bit match; bit rw; } addr_t;

  word_t exp_q[$];
  addr_t addr_q[$];
  bit    cur_match = 1'b0;
  word_t mw;
  addr_t ma;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compare on every address completion and every accepted word.
  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.addr_done) begin
        if (addr_q.size() == 0) begin
          check("unexpected_addr_done", 1, 0);
        end else begin
          ma = addr_q.pop_front();
          check("addr_match", bus.addr_match, ma.match);
          check("rw_bit", bus.rw_bit, ma.rw);
          check("ack_slot_addr", bus.ack_slot, 1);
        end
      end
      if (bus.rx_valid && bus.rx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", bus.rx_data, 256);
        end else begin
          mw = exp_q.pop_front();
          check("rx_data", bus.rx_data, mw.data);
          if (mw.lat) check("word_latency", cyc - mw.t, 1);
        end
      end
    end
  end

  task automatic tick(input logic sda, input logic rise, input logic st, input logic sp, input logic en);
    @(posedge clk); #1;
    bus.sda_in = sda; bus.rising_edge_found = rise;
    bus.start_found = st; bus.stop_found = sp; bus.rx_enable = en;
  endtask

  task automatic tick2(input logic sda, input logic rise, input logic st, input logic sp, input logic en);
    @(posedge clk); #1;
    bus2.sda_in = sda; bus2.rising_edge_found = rise;
    bus2.start_found = st; bus2.stop_found = sp; bus2.rx_enable = en;
  endtask

  // One sampled bit, preceded by random filler cycles (disabled edges included).
  task automatic send_bit(input logic b);
    int   gaps;
    logic en;
    gaps = $urandom_range(0, 2);
    for (int i = 0; i < gaps; i++) begin
      en = 1'($urandom_range(0, 1));
      tick(1'($urandom_range(0, 1)), en ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0, 1'b0, en);
    end
    tick(b, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_start(input logic with_edge);
    tick(1'b1, with_edge, 1'b1, 1'b0, 1'b1);
    cur_match = 1'b0;
  endtask

  task automatic send_stop();
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cur_match = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("match_after_stop", bus.addr_match, 0);
    check("rw_after_stop", bus.rw_bit, 0);
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rw);
    addr_t e;
    for (int i = 6; i >= 0; i--) send_bit(a[i]);
    send_bit(rw);
    e.match = (a == SLAVE);
    e.rw = rw;
    addr_q.push_back(e);
    cur_match = e.match;
    send_bit(1'($urandom_range(0, 1)));
  endtask

  // A full word is expected only after a matching address; an unread word
  // that is not being accepted is replaced by the newer one.
  task automatic send_byte(input logic [7:0] d, input int nbits);
    word_t w;
    for (int i = 0; i < nbits; i++) send_bit(d[7-i]);
    if (nbits == 8) begin
      if (cur_match) begin
        w.data = d; w.t = cyc; w.lat = bus.rx_ready;
        if (!bus.rx_ready && exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(w);
      end
      send_bit(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_data"}, bus.rx_data, 0);
    check({tag, "_rx_valid"}, bus.rx_valid, 0);
    check({tag, "_addr_done"}, bus.addr_done, 0);
    check({tag, "_addr_match"}, bus.addr_match, 0);
    check({tag, "_rw_bit"}, bus.rw_bit, 0);
    check({tag, "_ack_slot"}, bus.ack_slot, 0);
    check({tag, "_overrun"}, bus.overrun, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  logic [6:0] ra;
  logic       rrw;
  int         nb;
  logic [6:0] a2;

  initial begin
    n_rst = 1'b1;
    bus.sda_in = 1'b1; bus.rising_edge_found = 1'b0; bus.start_found = 1'b0;
    bus.stop_found = 1'b0; bus.rx_enable = 1'b0; bus.rx_ready = 1'b1;
    bus2.sda_in = 1'b1; bus2.rising_edge_found = 1'b0; bus2.start_found = 1'b0;
    bus2.stop_found = 1'b0; bus2.rx_enable = 1'b0; bus2.rx_ready = 1'b0;
    #1 n_rst = 1'b0;
    #20;
    check_all_zero("reset");
    @(posedge clk); #1 n_rst = 1'b1;

    // Matching write, one byte.
    send_start(1'b0);
    send_addr(SLAVE, 1'b0);
    send_byte(8'hA5, 8);
    send_stop();

    // Non-matching read: bytes that follow must never produce a word.
    send_start(1'b0);
    send_addr(7'h1F, 1'b1);
    send_byte(8'h5C, 8);
    send_byte(8'hE7, 8);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("nomatch_rx_valid", bus.rx_valid, 0);
    send_stop();

    // Overrun: two words with nobody accepting.
    bus.rx_ready = 1'b0;
    send_start(1'b0);
    send_addr(SLAVE, 1'b0);
    send_byte(8'h12, 8);
    send_byte(8'h34, 8);
    send_stop();
    check("ovr_rx_data", bus.rx_data, 8'h34);
    check("ovr_overrun", bus.overrun, 1);
    check("ovr_rx_valid", bus.rx_valid, 1);
    send_start(1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("start_clears_overrun", bus.overrun, 0);
    check("start_keeps_valid", bus.rx_valid, 1);
    check("start_keeps_data", bus.rx_data, 8'h34);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.rx_ready = 1'b1;
    send_stop();

    // Repeated START (with a coincident edge) after 4 bits of a word.
    send_start(1'b0);
    send_addr(SLAVE, 1'b0);
    send_byte(8'h5A, 8);
    send_byte(8'hF0, 4);
    send_start(1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("rstart_match_cleared", bus.addr_match, 0);
    check("rstart_rx_valid", bus.rx_valid, 0);
    send_addr(SLAVE, 1'b0);
    send_byte(8'hC3, 8);
    send_stop();

    // Asynchronous reset in the middle of a word.
    bus.rx_ready = 1'b0;
    send_start(1'b0);
    send_addr(SLAVE, 1'b0);
    send_byte(8'h77, 8);
    send_byte(8'h81, 3);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("pre_reset_valid", bus.rx_valid, 1);
    check("pre_reset_match", bus.addr_match, 1);
    #2 n_rst = 1'b0;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    cur_match = 1'b0;
    @(posedge clk); #1 n_rst = 1'b1;
    bus.rx_ready = 1'b1;
    send_start(1'b0);
    send_addr(SLAVE, 1'b0);
    send_byte(8'h3C, 8);
    send_stop();

    // LSB-first, 4-bit instance: address LSB first, data 1,0,0,0 with a
    // 3-edge rx_enable gap mid-word.
    a2 = SLAVE;
    tick2(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) tick2(a2[i], 1'b1, 1'b0, 1'b0, 1'b1);
    tick2(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick2(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick2(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick2(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick2(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick2(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick2(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick2(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("lsb_addr_match", bus2.addr_match, 1);
    check("lsb_rx_data", bus2.rx_data, 4'h1);
    check("lsb_rx_valid", bus2.rx_valid, 1);
    tick2(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick2(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomised transactions: random addresses, lengths, aborts, repeated STARTs.
    for (int n = 0; n < 40; n++) begin
      ra  = ($urandom_range(0, 1) == 1) ? SLAVE : 7'($urandom);
      rrw = 1'($urandom_range(0, 1));
      nb  = $urandom_range(1, 3);
      send_start(1'($urandom_range(0, 1)));
      send_addr(ra, rrw);
      for (int b = 0; b < nb; b++) begin
        if (b == nb - 1 && $urandom_range(0, 3) == 0) send_byte(8'($urandom), $urandom_range(1, 7));
        else send_byte(8'($urandom), 8);
      end
      if ($urandom_range(0, 3) != 0) send_stop();
    end
    send_stop();

    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("words_outstanding", exp_q.size(), 0);
    check("addrs_outstanding", addr_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
